// File: rtl/apb_reg_ctrl.sv
// APB access sequencer for the I2S register map (0x0 Tx data, 0x4 control, 0x8 Rx data).
// Produces one-cycle register strobes, wait states on Tx/Rx back-pressure, and error responses.
module apb_reg_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic        tx_full,
  input  logic        rx_valid,
  output logic        pready,
  output logic        pslverr,
  output logic        reg_wen,
  output logic        reg_ren,
  output logic        rx_ack,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    STROBE,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [31:0]   addr_q;
  logic          write_q;
  logic [CW-1:0] wait_cnt;

  logic acc_tx;
  logic acc_rx;
  logic acc_ctl;
  logic acc_ok;
  logic res_ready;
  logic timeout;
  logic next_err;

  logic pready_d;
  logic pslverr_d;
  logic reg_wen_d;
  logic reg_ren_d;

  always_comb begin
    acc_tx    = write_q && (addr_q == 32'h0000_0000);
    acc_rx    = !write_q && (addr_q == 32'h0000_0008);
    acc_ctl   = (addr_q == 32'h0000_0004);
    acc_ok    = acc_tx || acc_rx || acc_ctl;
    res_ready = acc_tx ? !tx_full : (acc_rx ? rx_valid : 1'b1);
    timeout   = (wait_cnt == CW'(MAX_WAIT));
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state    <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wait_cnt <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      reg_wen  <= 1'b0;
      reg_ren  <= 1'b0;
      rx_ack   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == ACCESS) begin
        addr_q   <= paddr;
        write_q  <= pwrite;
        wait_cnt <= '0;
      end else if (state == WAIT && next_state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      pready  <= pready_d;
      pslverr <= pslverr_d;
      reg_wen <= reg_wen_d;
      reg_ren <= reg_ren_d;
      rx_ack  <= reg_ren_d;
      if (pslverr_d && err_cnt != '1) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Timeout wins over a late-arriving resource on the final wait cycle,
  // which bounds a successful transfer at 4+MAX_WAIT cycles.
  always_comb begin
    next_state = state;
    next_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && !penable) next_state = ACCESS;
      end
      ACCESS: begin
        if (!psel) begin
          next_state = IDLE;
        end else if (!acc_ok) begin
          next_state = DONE;
          next_err   = 1'b1;
        end else if (res_ready) begin
          next_state = STROBE;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          next_state = IDLE;
        end else if (timeout) begin
          next_state = DONE;
          next_err   = 1'b1;
        end else if (res_ready) begin
          next_state = STROBE;
        end
      end
      STROBE: begin
        next_state = psel ? DONE : IDLE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    pready_d  = (next_state == DONE);
    pslverr_d = (next_state == DONE) && next_err;
    reg_wen_d = (next_state == STROBE) && acc_tx;
    reg_ren_d = (next_state == STROBE) && acc_rx;
  end

endmodule
